// File: rtl/spi_lcd_link.sv
// Write-only SPI mode-0 link for an LCD controller: 9-bit {dc,byte} FIFO feeding a
// serialiser that holds off after power commands (SWRESET/SLPIN/SLPOUT).
module spi_lcd_link #(
   parameter int FREQ       = 25_000_000,
   parameter int DELAY      = 120,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       dc,
   input  logic [7:0] in,
   input  logic       put,
   output logic       full,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       LCD_reset_n,
   output logic       LCD_clock,
   output logic       LCD_cs_n,
   output logic       LCD_dc,
   output logic       LCD_mosi,
   input  logic       LCD_miso
);
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int TIMEOUT = DELAY * (FREQ / 1000);
   localparam int CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, WAIT} state_e;

   logic [8:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  push, pop, empty;
   logic [8:0]            head;

   assign full        = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign push        = put && !full;
   assign head        = mem_q[rptr_q];
   assign LCD_reset_n = reset_n;

   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= {dc, in};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   state_e         state_q, state_d;
   logic           cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d, dc_q, dc_d;
   logic [6:0]     sh_q, sh_d, rx_sh_q, rx_sh_d;
   logic [2:0]     bit_q, bit_d;
   logic           pwr_q, pwr_d, rx_valid_q, rx_valid_d;
   logic [7:0]     rx_data_q, rx_data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           do_load;

   assign LCD_clock = sck_q;
   assign LCD_cs_n  = cs_n_q;
   assign LCD_dc    = dc_q;
   assign LCD_mosi  = mosi_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;

   // LOAD already drives the MSB with SCK low, so a frame is exactly 16 cycles of CS low.
   always_comb begin
      state_d    = state_q;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      dc_d       = dc_q;
      sh_d       = sh_q;
      bit_d      = bit_q;
      pwr_d      = pwr_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      cnt_d      = cnt_q;
      do_load    = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: if (!empty) do_load = 1'b1;
         LOAD, SHIFT_LO: begin
            state_d = SHIFT_HI;
            sck_d   = 1'b1;
         end
         SHIFT_HI: begin
            rx_sh_d = {rx_sh_q[5:0], LCD_miso};
            sck_d   = 1'b0;
            if (bit_q == 3'd7) begin
               rx_data_d  = {rx_sh_q, LCD_miso};
               rx_valid_d = 1'b1;
               if (pwr_q) begin
                  state_d = WAIT;
                  cs_n_d  = 1'b1;
                  cnt_d   = CW'(TIMEOUT);
               end else if (!empty) begin
                  do_load = 1'b1;
               end else begin
                  state_d = IDLE;
                  cs_n_d  = 1'b1;
               end
            end else begin
               state_d = SHIFT_LO;
               mosi_d  = sh_q[6];
               sh_d    = {sh_q[5:0], 1'b0};
               bit_d   = bit_q + 3'd1;
            end
         end
         WAIT: begin
            // Leaving on the last count lets a pending entry load right away, so CS stays
            // high for exactly TIMEOUT cycles.
            if (cnt_q <= CW'(1)) begin
               if (!empty) do_load = 1'b1;
               else        state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (do_load) begin
         pop     = 1'b1;
         state_d = LOAD;
         cs_n_d  = 1'b0;
         sck_d   = 1'b0;
         dc_d    = head[8];
         mosi_d  = head[7];
         sh_d    = head[6:0];
         bit_d   = 3'd0;
         pwr_d   = (head == 9'h001) || (head == 9'h010) || (head == 9'h011);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         dc_q       <= 1'b0;
         sh_q       <= '0;
         bit_q      <= '0;
         pwr_q      <= 1'b0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cs_n_q     <= cs_n_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         dc_q       <= dc_d;
         sh_q       <= sh_d;
         bit_q      <= bit_d;
         pwr_q      <= pwr_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         cnt_q      <= cnt_d;
      end
   end
endmodule

// File: tb/tb_spi_lcd_link.sv
// Bench for spi_lcd_link: queued words are the expected SPI frames; a bus monitor
// decodes frames from the pins and checks them, the rx pulses and CS timing.
module tb_spi_lcd_link;
   localparam int TIMEOUT = 1000;

   logic       clock = 0, reset_n = 0, dc_i = 0, put = 0;
   logic [7:0] in_b = 0;
   logic       full, rx_valid, LCD_reset_n, LCD_clock, LCD_cs_n, LCD_dc, LCD_mosi, LCD_miso;
   logic [7:0] rx_data;

   assign LCD_miso = LCD_mosi;
   always #5 clock = ~clock;

   spi_lcd_link #(.FREQ(1_000_000), .DELAY(1), .DEPTH_LOG2(4)) dut (
      .clock(clock), .reset_n(reset_n), .dc(dc_i), .in(in_b), .put(put), .full(full),
      .rx_data(rx_data), .rx_valid(rx_valid), .LCD_reset_n(LCD_reset_n),
      .LCD_clock(LCD_clock), .LCD_cs_n(LCD_cs_n), .LCD_dc(LCD_dc), .LCD_mosi(LCD_mosi),
      .LCD_miso(LCD_miso));

   int checks = 0, failures = 0;
   logic [8:0] exp_q[$];
   logic [7:0] rx_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Bus monitor
   int mbits = 0, low_cnt = 0, hi_cnt = 0, burst = 0, frames = 0, last_low = 0, last_gap = 0;
   logic prev_cs = 1, prev_sck = 0, prev_dc = 0, prev_mosi = 0, last_pwr = 0, fr_dc = 0;
   logic [7:0] fr = 0;
   logic [8:0] e;

   always @(negedge clock) begin
      if (!reset_n) begin
         mbits = 0; low_cnt = 0; hi_cnt = 0; burst = 0; last_pwr = 0;
         prev_cs = 1; prev_sck = 0; prev_dc = 0; prev_mosi = 0;
      end else begin
         if (!LCD_cs_n) begin
            if (prev_cs) begin
               if (last_pwr) check("holdoff_gap_min", 32'(hi_cnt >= TIMEOUT), 1);
               last_gap = hi_cnt; low_cnt = 0; burst = 0;
            end
            low_cnt++;
            if (LCD_clock && !prev_sck) begin
               if (mbits == 0) fr_dc = LCD_dc;
               else check("dc_stable", LCD_dc, fr_dc);
               fr = {fr[6:0], LCD_mosi};
               mbits++;
               if (mbits == 8) begin
                  mbits = 0; burst++; frames++;
                  if (exp_q.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_frame: got %0h expected none", {fr_dc, fr});
                  end else begin
                     e = exp_q.pop_front();
                     check("frame", {fr_dc, fr}, e);
                     rx_q.push_back(e[7:0]);
                     last_pwr = (e == 9'h001) || (e == 9'h010) || (e == 9'h011);
                  end
               end
            end
         end else begin
            if (!prev_cs) begin
               last_low = low_cnt;
               check("burst_len", low_cnt, 16 * burst);
               check("frame_whole", mbits, 0);
               hi_cnt = 0;
            end
            hi_cnt++;
         end
         if (LCD_dc !== prev_dc)     check("dc_change_sck_low", LCD_clock, 0);
         if (LCD_mosi !== prev_mosi) check("mosi_change_sck_low", LCD_clock, 0);
         if (rx_valid) begin
            if (rx_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rx: got %0h expected none", rx_data);
            end else check("rx_data", rx_data, rx_q.pop_front());
         end
         prev_cs = LCD_cs_n; prev_sck = LCD_clock; prev_dc = LCD_dc; prev_mosi = LCD_mosi;
      end
   end

   // Called at a negedge; the word is sampled at the following posedge.
   task automatic put_w(input logic [8:0] w, input bit acc);
      dc_i = w[8]; in_b = w[7:0]; put = 1;
      if (acc) exp_q.push_back(w);
      @(negedge clock);
      put = 0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || rx_q.size() != 0 || !LCD_cs_n) && n < budget) begin
         @(negedge clock); n++;
      end
      check("drain_timeout", 32'(n >= budget), 0);
      repeat (3) @(negedge clock);
   endtask

   task automatic check_reset_pins();
      check("rst_cs_n", LCD_cs_n, 1);
      check("rst_sck", LCD_clock, 0);
      check("rst_mosi", LCD_mosi, 0);
      check("rst_dc", LCD_dc, 0);
      check("rst_full", full, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_lcd_reset_n", LCD_reset_n, 0);
   endtask

   initial begin
      logic [8:0] w;
      int n, np, g, f0;
      #12;
      check_reset_pins();
      @(negedge clock); #2 reset_n = 1; #1;
      check("lcd_reset_n_release", LCD_reset_n, 1);
      repeat (20) @(negedge clock);
      check("idle_cs_n", LCD_cs_n, 1);
      check("idle_frames", frames, 0);

      put_w(9'h1A5, 1);
      drain(200);
      check("single_cs_low", last_low, 16);
      check("single_rx", rx_data, 8'hA5);

      put_w(9'h02A, 1); put_w(9'h100, 1); put_w(9'h17F, 1);
      drain(300);
      check("b2b_cs_low", last_low, 48);
      check("b2b_frames", frames, 4);

      put_w(9'h011, 1); put_w(9'h155, 1);
      drain(3000);
      check("holdoff_gap", last_gap, TIMEOUT);
      check("holdoff_second_low", last_low, 16);

      put_w(9'h111, 1); put_w(9'h155, 1);
      drain(300);
      check("data_11_no_gap", last_low, 32);

      put_w(9'h001, 1);
      drain(300);
      for (int i = 0; i < 17; i++) begin
         put_w({1'b1, 8'(i * 7 + 3)}, i < 16);
         check("full_flag", full, 32'(i >= 15));
      end
      n = 0;
      while (LCD_cs_n && n < 1100) begin @(negedge clock); n++; end
      check("full_wait_timeout", 32'(n >= 1100), 0);
      check("full_clear_on_pop", full, 0);
      drain(1000);

      np = 0;
      for (int k = 0; k < 60; k++) begin
         g = $urandom_range(0, 20);
         repeat (g) @(negedge clock);
         n = 0;
         while (exp_q.size() >= 12 && n < 3000) begin @(negedge clock); n++; end
         if (n >= 3000) check("throttle_timeout", 32'(n), 0);
         w = {1'($urandom_range(0, 1)), 8'($urandom)};
         if ($urandom_range(0, 15) == 0 && np < 3) begin
            case ($urandom_range(0, 2))
               0: w = 9'h001;
               1: w = 9'h010;
               default: w = 9'h011;
            endcase
            np++;
         end
         put_w(w, 1);
      end
      drain(6000);
      check("random_all_sent", exp_q.size(), 0);

      put_w(9'h1C3, 1); put_w(9'h13C, 1); put_w(9'h1F0, 1);
      n = 0;
      while (mbits != 3 && n < 3000) begin @(negedge clock); n++; end
      check("midframe_wait_timeout", 32'(n >= 3000), 0);
      #2 reset_n = 0; #1;
      check_reset_pins();
      @(negedge clock); @(negedge clock);
      exp_q.delete(); rx_q.delete();
      f0 = frames;
      #2 reset_n = 1;
      repeat (40) @(negedge clock);
      check("post_reset_cs_n", LCD_cs_n, 1);
      check("post_reset_no_frames", frames, f0);
      check("post_reset_full", full, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_lcd_link.md
Name: spi_lcd_link

Overview:
- Write-only SPI link for an LCD controller.
- Command/data bytes are queued in a 16-entry FIFO and serialised by an SPI mode-0 master.
- After a power-class command (SWRESET, SLPIN, SLPOUT) the link holds off further traffic for a programmable millisecond delay.
- Sits between the display-drawing logic and the LCD pins.

Parameters:
- FREQ, 25_000_000: system clock frequency in Hz.
- DELAY, 120: hold-off after a power command, in ms.
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries, each 9 bits wide ({dc, byte}).

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- dc  in  1  0 = command byte, 1 = data byte; qualified by put.
- in  in  8  byte to queue.
- put  in  1  write strobe, sampled at the rising clock edge.
- full  out  1  FIFO full; a put while full is dropped.
- rx_data  out  8  byte shifted in from LCD_miso during the last frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- LCD_reset_n  out  1  equals reset_n (combinational).
- LCD_clock  out  1  SCK, idles low.
- LCD_cs_n  out  1  chip select, idles high.
- LCD_dc  out  1  D/C line.
- LCD_mosi  out  1  serial data out, MSB first.
- LCD_miso  in  1  serial data in.

Behaviour:
Reset (reset_n low): all outputs take these values immediately.
- FIFO emptied; full=0.
- LCD_cs_n=1, LCD_clock=0, LCD_mosi=0, LCD_dc=0.
- rx_valid=0, rx_data=0.
- Hold-off timer cleared (not waiting).

FIFO:
- Synchronous, single clock, 9 bits wide, 2^DEPTH_LOG2 entries.
- full is asserted when the entry count equals the depth.
- A put while full is ignored; contents are unchanged.
- Simultaneous put and pop when non-full both take effect.
- Pointers wrap modulo the depth.

Master FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, WAIT.
- IDLE: transition to LOAD when the FIFO is non-empty and the hold-off is inactive.
- LOAD (1 cycle):
  - pop the head entry;
  - LCD_dc <= entry[8];
  - shift register <= entry[7:0];
  - LCD_cs_n <= 0.
- SHIFT_LO (1 cycle): LCD_clock=0, LCD_mosi = current MSB.
- SHIFT_HI (1 cycle):
  - LCD_clock=1;
  - sample LCD_miso into the receive register;
  - after bit 0, the frame ends.
- Frame timing: 8 bits x 2 cycles = 16 cycles after LOAD.
- LCD_dc and LCD_mosi change only while LCD_clock is low.
- Frame end:
  - rx_data updated, rx_valid pulses for 1 cycle.
  - If the sent entry is a power command, go to WAIT with LCD_cs_n=1.
  - Otherwise, if the FIFO is non-empty, go straight to LOAD with LCD_cs_n held low (back-to-back frames).
  - Otherwise go to IDLE with LCD_cs_n=1.
- Power command: an entry of exactly 9'h001, 9'h010 or 9'h011 (dc=0). Data bytes with the same value (dc=1) do not trigger the hold-off.

WAIT:
- Counter loaded with TIMEOUT = DELAY*(FREQ/1000) clock cycles, width $clog2(TIMEOUT+1).
- Counts down to 0, then enters IDLE.
- No pops and LCD_cs_n=1 throughout.
- FIFO writes continue to be accepted during WAIT.

Latency and other rules:
- A put into an empty idle link at edge N gives LOAD at edge N+1, and LCD_cs_n falls after edge N+1.
- Reset mid-frame aborts the frame and leaves the pins at their reset values.
- LCD_reset_n follows reset_n with no delay.

Test Plan:
- Reset: with reset_n=0 -> LCD_cs_n=1, LCD_clock=0, full=0, LCD_reset_n=0; after release -> LCD_reset_n=1 and the link stays idle.
- Single byte: put dc=1, in=8'hA5 -> LCD_cs_n low for 16 cycles; 8 rising LCD_clock edges; LCD_mosi bits 1,0,1,0,0,1,0,1 at each rising edge; LCD_dc=1 throughout; LCD_cs_n=1 afterwards.
- Back-to-back and MISO: queue {0,8'h2A},{1,8'h00},{1,8'h7F} with LCD_miso tied to LCD_mosi -> LCD_cs_n stays low for 48 cycles; LCD_dc sequence 0,1,1; rx_data sequence 2A, 00, 7F with three rx_valid pulses.
- Hold-off (FREQ=1_000_000, DELAY=1): queue {0,8'h11} then {1,8'h55} -> exactly 1000 cycles with LCD_cs_n=1 between the two frames. Repeat with {1,8'h11} first -> no gap.
- FIFO full: stall the link with a hold-off, then issue 17 puts -> full asserts after the 16th; the 17th is dropped; 16 frames are sent in order; full clears on the first pop.
- Async reset mid-frame: assert reset_n=0 during bit 3 -> pins return to reset values in the same cycle; the FIFO is empty after release.
